// File: rtl/layer_pkg.sv
// Shared definitions for the layer sequencer: descriptor field map,
// FSM state encodings and descriptor pack/unpack helpers.
package layer_pkg;

    localparam int MAX_LAYER_DEF = 16;
    localparam int OFM_RAM_SIZE  = 2378675;
    localparam int AW            = $clog2(OFM_RAM_SIZE);
    localparam int SIZE_W        = 9;
    localparam int CH_W          = 11;
    localparam int KS_W          = 2;
    localparam int PSTR_W        = 2;

    // Descriptor field map, packed LSB first.
    localparam int SIZE_LSB  = 0;
    localparam int CH_LSB    = SIZE_LSB + SIZE_W;
    localparam int KS_LSB    = CH_LSB + CH_W;
    localparam int FILT_LSB  = KS_LSB + KS_W;
    localparam int POOL_LSB  = FILT_LSB + CH_W;
    localparam int PSTR_LSB  = POOL_LSB + 1;
    localparam int UPS_LSB   = PSTR_LSB + PSTR_W;
    localparam int WADDR_LSB = UPS_LSB + 1;
    localparam int RADDR_LSB = WADDR_LSB + AW;
    localparam int DESC_W    = RADDR_LSB + AW;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_LAUNCH = 3'd2;
    localparam logic [2:0] ST_RUN    = 3'd3;
    localparam logic [2:0] ST_FINISH = 3'd4;

    typedef struct packed {
        logic [AW-1:0]     start_read_addr;
        logic [AW-1:0]     start_write_addr;
        logic              upsample_mode;
        logic [PSTR_W-1:0] maxpool_stride;
        logic              maxpool_mode;
        logic [CH_W-1:0]   num_filter;
        logic [KS_W-1:0]   kernel_size;
        logic [CH_W-1:0]   ifm_channel;
        logic [SIZE_W-1:0] ifm_size;
    } layer_desc_t;

    function automatic logic [DESC_W-1:0] desc_pack(input layer_desc_t d);
        logic [DESC_W-1:0] w;
        w = '0;
        w[SIZE_LSB  +: SIZE_W] = d.ifm_size;
        w[CH_LSB    +: CH_W]   = d.ifm_channel;
        w[KS_LSB    +: KS_W]   = d.kernel_size;
        w[FILT_LSB  +: CH_W]   = d.num_filter;
        w[POOL_LSB]            = d.maxpool_mode;
        w[PSTR_LSB  +: PSTR_W] = d.maxpool_stride;
        w[UPS_LSB]             = d.upsample_mode;
        w[WADDR_LSB +: AW]     = d.start_write_addr;
        w[RADDR_LSB +: AW]     = d.start_read_addr;
        return w;
    endfunction

    function automatic layer_desc_t desc_unpack(input logic [DESC_W-1:0] w);
        layer_desc_t d;
        d.ifm_size         = w[SIZE_LSB  +: SIZE_W];
        d.ifm_channel      = w[CH_LSB    +: CH_W];
        d.kernel_size      = w[KS_LSB    +: KS_W];
        d.num_filter       = w[FILT_LSB  +: CH_W];
        d.maxpool_mode     = w[POOL_LSB];
        d.maxpool_stride   = w[PSTR_LSB  +: PSTR_W];
        d.upsample_mode    = w[UPS_LSB];
        d.start_write_addr = w[WADDR_LSB +: AW];
        d.start_read_addr  = w[RADDR_LSB +: AW];
        return d;
    endfunction

endpackage

// File: rtl/layer_desc_ram.sv
// Descriptor table: one write port, one registered read port, no reset so
// it maps onto block RAM and keeps its contents across a controller reset.
module layer_desc_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 81,
    localparam int RAW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [RAW-1:0]   waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [RAW-1:0]   raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Host write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read: data is valid the cycle after re.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/layer_sequencer.sv
// Programmable per-layer sequencer: walks a host-loaded descriptor table,
// presents each layer's configuration and handshakes with the layer engine.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  IDLE      | waiting for start_CNN; table writable
//  FETCH     | registered table read of descriptor idx
//  LAUNCH    | config registers load, start_layer pulses
//  RUN       | engine busy on current layer, waiting for done_layer
//  FINISH    | done_CNN pulse, count_layer cleared
module layer_sequencer
    import layer_pkg::*;
#(
    parameter int MAX_LAYER = MAX_LAYER_DEF,
    localparam int LW = $clog2(MAX_LAYER + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [LW-1:0]     cfg_addr,
    input  logic [DESC_W-1:0] cfg_wdata,
    input  logic [LW-1:0]     num_layer,
    input  logic              start_CNN,
    input  logic              abort,
    input  logic              done_layer,
    output logic              start_layer,
    output logic              done_CNN,
    output logic              busy,
    output logic              cfg_err,
    output logic [LW-1:0]     count_layer,
    output logic [SIZE_W-1:0] ifm_size,
    output logic [CH_W-1:0]   ifm_channel,
    output logic [KS_W-1:0]   kernel_size,
    output logic [CH_W-1:0]   num_filter,
    output logic              maxpool_mode,
    output logic [PSTR_W-1:0] maxpool_stride,
    output logic              upsample_mode,
    output logic [AW-1:0]     start_write_addr,
    output logic [AW-1:0]     start_read_addr
);

    localparam int RAW = $clog2(MAX_LAYER);
    localparam logic [LW-1:0] MAX_N = LW'(MAX_LAYER);

    logic [2:0]        state;
    logic [RAW-1:0]    idx;
    logic [LW-1:0]     n_layers;
    layer_desc_t       cfg_q;
    logic [DESC_W-1:0] rd_data;
    logic              wr_ok;
    logic              wr_bad;
    logic              stray_done;
    logic              over_req;
    logic              last_layer;

    assign busy        = (state != ST_IDLE);
    assign start_layer = (state == ST_LAUNCH) && !abort;
    assign done_CNN    = (state == ST_FINISH) && !abort;

    assign wr_ok      = cfg_we && !busy && (cfg_addr < MAX_N);
    assign wr_bad     = cfg_we && !wr_ok;
    assign stray_done = done_layer && (state != ST_RUN);
    assign over_req   = (state == ST_IDLE) && start_CNN && (num_layer > MAX_N);
    assign last_layer = (LW'(idx) == n_layers - LW'(1));

    layer_desc_ram #(
        .DEPTH (MAX_LAYER),
        .WIDTH (DESC_W)
    ) u_desc_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (cfg_addr[RAW-1:0]),
        .wdata (cfg_wdata),
        .re    (state == ST_FETCH),
        .raddr (idx),
        .rdata (rd_data)
    );

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_err <= 1'b0;
        end else if (wr_bad || stray_done || over_req) begin
            cfg_err <= 1'b1;
        end
    end

    // Sequencing FSM; abort from any busy state overrides everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            n_layers    <= '0;
            count_layer <= '0;
            cfg_q       <= '0;
        end else if (abort && busy) begin
            state       <= ST_IDLE;
            count_layer <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_CNN && !over_req) begin
                        n_layers <= num_layer;
                        idx      <= '0;
                        state    <= (num_layer == '0) ? ST_FINISH : ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    count_layer <= LW'(idx) + LW'(1);
                    state       <= ST_LAUNCH;
                end
                ST_LAUNCH: begin
                    cfg_q <= desc_unpack(rd_data);
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    if (done_layer) begin
                        if (last_layer) begin
                            state <= ST_FINISH;
                        end else begin
                            idx   <= idx + RAW'(1);
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_FINISH: begin
                    count_layer <= '0;
                    state       <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ifm_size         = cfg_q.ifm_size;
    assign ifm_channel      = cfg_q.ifm_channel;
    assign kernel_size      = cfg_q.kernel_size;
    assign num_filter       = cfg_q.num_filter;
    assign maxpool_mode     = cfg_q.maxpool_mode;
    assign maxpool_stride   = cfg_q.maxpool_stride;
    assign upsample_mode    = cfg_q.upsample_mode;
    assign start_write_addr = cfg_q.start_write_addr;
    assign start_read_addr  = cfg_q.start_read_addr;

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer: emulates the host and the layer
// engine, queues expected per-layer configs and compares on each launch.
module tb_layer_sequencer;

    localparam int DW = 81;
    localparam int LW = 5;

    logic          clk;
    logic          rst;
    logic          cfg_we;
    logic [LW-1:0] cfg_addr;
    logic [DW-1:0] cfg_wdata;
    logic [LW-1:0] num_layer;
    logic          start_CNN;
    logic          abort;
    logic          done_layer;
    logic          start_layer;
    logic          done_CNN;
    logic          busy;
    logic          cfg_err;
    logic [LW-1:0] count_layer;
    logic [8:0]    ifm_size;
    logic [10:0]   ifm_channel;
    logic [1:0]    kernel_size;
    logic [10:0]   num_filter;
    logic          maxpool_mode;
    logic [1:0]    maxpool_stride;
    logic          upsample_mode;
    logic [21:0]   start_write_addr;
    logic [21:0]   start_read_addr;
    logic [DW-1:0] obs_cfg;

    int errors   = 0;
    int checks   = 0;
    int sl_count = 0;
    int dc_count = 0;

    logic [DW-1:0] tb_tab [16];
    logic [DW-1:0] exp_q [$];

    assign obs_cfg = {start_read_addr, start_write_addr, upsample_mode, maxpool_stride,
                      maxpool_mode, num_filter, kernel_size, ifm_channel, ifm_size};

    layer_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_we           (cfg_we),
        .cfg_addr         (cfg_addr),
        .cfg_wdata        (cfg_wdata),
        .num_layer        (num_layer),
        .start_CNN        (start_CNN),
        .abort            (abort),
        .done_layer       (done_layer),
        .start_layer      (start_layer),
        .done_CNN         (done_CNN),
        .busy             (busy),
        .cfg_err          (cfg_err),
        .count_layer      (count_layer),
        .ifm_size         (ifm_size),
        .ifm_channel      (ifm_channel),
        .kernel_size      (kernel_size),
        .num_filter       (num_filter),
        .maxpool_mode     (maxpool_mode),
        .maxpool_stride   (maxpool_stride),
        .upsample_mode    (upsample_mode),
        .start_write_addr (start_write_addr),
        .start_read_addr  (start_read_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (start_layer) sl_count++;
        if (done_CNN) dc_count++;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: time %0t reached without finishing", $time);
        $fatal(1, "watchdog expired");
    end

    // Descriptor i, packed {raddr, waddr, ups, stride, pool, filt, k, ch, size}.
    function automatic logic [DW-1:0] mk(input int i);
        logic [8:0]  sz;
        logic [10:0] ch;
        logic [10:0] fl;
        logic [1:0]  k;
        logic [1:0]  ps;
        logic        pm;
        logic        up;
        logic [21:0] wa;
        logic [21:0] ra;
        if (i == 0) begin
            sz = 9'd414; ch = 11'd3; k = 2'd3; fl = 11'd16; pm = 1'b1; ps = 2'd2;
            up = 1'b0; wa = 22'd0; ra = 22'd2378674;
        end else begin
            sz = 9'(414 - i * 26);
            ch = 11'(i * 32 + 3);
            k  = (i % 2 == 1) ? 2'd1 : 2'd3;
            fl = 11'(16 << (i % 6));
            pm = (i % 3 == 0);
            ps = 2'(i % 3);
            up = (i % 4 == 1);
            wa = 22'(i * 180000 + 7);
            ra = 22'(2378674 - i * 4096);
        end
        return {ra, wa, up, ps, pm, fl, k, ch, sz};
    endfunction

    task automatic cfg_write(input int a, input logic [DW-1:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = LW'(a);
        cfg_wdata = d;
        @(negedge clk);
        cfg_we    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Steps cycles until start_layer is seen (bounded); one-shot inputs drop after one cycle.
    task automatic wait_launch(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            start_CNN  = 1'b0;
            done_layer = 1'b0;
            abort      = 1'b0;
            cfg_we     = 1'b0;
            cyc++;
        end while (!start_layer && cyc < 20);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({start_layer, done_CNN, busy, cfg_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000", {start_layer, done_CNN, busy, cfg_err});
        end
        checks++;
        if (count_layer !== '0 || obs_cfg !== '0) begin
            errors++;
            $display("FAIL reset_outputs: count %0d cfg %h expected 0", count_layer, obs_cfg);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy %b expected 0", busy);
        end
    endtask

    task automatic test_full_run();
        int cyc;
        int sl0;
        int dc0;
        logic [DW-1:0] e;
        for (int i = 0; i < 13; i++) begin
            tb_tab[i] = mk(i);
            cfg_write(i, tb_tab[i]);
        end
        sl0 = sl_count;
        dc0 = dc_count;
        for (int i = 0; i < 13; i++) exp_q.push_back(tb_tab[i]);
        num_layer = 5'd13;
        start_CNN = 1'b1;
        for (int k = 0; k < 13; k++) begin
            wait_launch(cyc);
            checks++;
            if (cyc != 2) begin
                errors++;
                $display("FAIL full_latency layer %0d: got %0d cycles expected 2", k + 1, cyc);
            end
            checks++;
            if (count_layer !== LW'(k + 1)) begin
                errors++;
                $display("FAIL full_count layer %0d: got %0d expected %0d", k + 1, count_layer, k + 1);
            end
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs_cfg !== e) begin
                errors++;
                $display("FAIL full_cfg layer %0d: got %h expected %h", k + 1, obs_cfg, e);
            end
            repeat (k % 3) @(negedge clk);
            checks++;
            if (start_layer !== 1'b0 || busy !== 1'b1 || obs_cfg !== e) begin
                errors++;
                $display("FAIL full_hold layer %0d: start %b busy %b cfg %h expected 0 1 %h",
                         k + 1, start_layer, busy, obs_cfg, e);
            end
            done_layer = 1'b1;
        end
        @(negedge clk);
        done_layer = 1'b0;
        checks++;
        if (done_CNN !== 1'b1) begin
            errors++;
            $display("FAIL full_done_latency: done_CNN %b expected 1", done_CNN);
        end
        @(negedge clk);
        checks++;
        if (done_CNN !== 1'b0 || busy !== 1'b0 || count_layer !== '0) begin
            errors++;
            $display("FAIL full_end: done %b busy %b count %0d expected 0 0 0", done_CNN, busy, count_layer);
        end
        checks++;
        if (obs_cfg !== tb_tab[12]) begin
            errors++;
            $display("FAIL full_cfg_hold: got %h expected %h", obs_cfg, tb_tab[12]);
        end
        @(negedge clk);
        checks++;
        if (sl_count - sl0 != 13 || dc_count - dc0 != 1) begin
            errors++;
            $display("FAIL full_pulses: start_layer %0d done_CNN %0d expected 13 1", sl_count - sl0, dc_count - dc0);
        end
    endtask

    task automatic test_zero_layers();
        int sl0;
        int dc0;
        sl0 = sl_count;
        dc0 = dc_count;
        num_layer = 5'd0;
        start_CNN = 1'b1;
        @(negedge clk);
        start_CNN = 1'b0;
        checks++;
        if (done_CNN !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL zero_done: done %b busy %b expected 1 1", done_CNN, busy);
        end
        @(negedge clk);
        checks++;
        if (done_CNN !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_idle: done %b busy %b expected 0 0", done_CNN, busy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (sl_count - sl0 != 0 || dc_count - dc0 != 1) begin
            errors++;
            $display("FAIL zero_pulses: start_layer %0d done_CNN %0d expected 0 1", sl_count - sl0, dc_count - dc0);
        end
    endtask

    task automatic test_abort();
        int cyc;
        int sl0;
        int dc0;
        sl0 = sl_count;
        dc0 = dc_count;
        num_layer = 5'd3;
        start_CNN = 1'b1;
        wait_launch(cyc);
        @(negedge clk);
        done_layer = 1'b1;
        wait_launch(cyc);
        checks++;
        if (cyc != 2 || count_layer !== 5'd2) begin
            errors++;
            $display("FAIL abort_layer2: latency %0d count %0d expected 2 2", cyc, count_layer);
        end
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || count_layer !== '0 || done_CNN !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: busy %b count %0d done %b expected 0 0 0", busy, count_layer, done_CNN);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (dc_count - dc0 != 0 || sl_count - sl0 != 2) begin
            errors++;
            $display("FAIL abort_pulses: done_CNN %0d start_layer %0d expected 0 2", dc_count - dc0, sl_count - sl0);
        end
        exp_q.push_back(tb_tab[0]);
        num_layer = 5'd1;
        start_CNN = 1'b1;
        wait_launch(cyc);
        checks++;
        if (cyc != 2 || count_layer !== 5'd1) begin
            errors++;
            $display("FAIL abort_restart: latency %0d count %0d expected 2 1", cyc, count_layer);
        end
        @(negedge clk);
        checks++;
        if (obs_cfg !== exp_q[0]) begin
            errors++;
            $display("FAIL abort_restart_cfg: got %h expected %h", obs_cfg, exp_q[0]);
        end
        void'(exp_q.pop_front());
        done_layer = 1'b1;
        @(negedge clk);
        done_layer = 1'b0;
        checks++;
        if (done_CNN !== 1'b1 || cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL abort_restart_done: done %b err %b expected 1 0", done_CNN, cfg_err);
        end
        @(negedge clk);
    endtask

    task automatic test_write_busy();
        int cyc;
        logic [DW-1:0] e;
        checks++;
        if (cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL wb_err_before: got %b expected 0", cfg_err);
        end
        for (int i = 0; i < 3; i++) exp_q.push_back(tb_tab[i]);
        num_layer = 5'd3;
        start_CNN = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_launch(cyc);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs_cfg !== e || cyc != 2) begin
                errors++;
                $display("FAIL wb_cfg layer %0d: got %h latency %0d expected %h 2", k + 1, obs_cfg, cyc, e);
            end
            if (k == 1) begin
                cfg_write(2, mk(22));
                checks++;
                if (cfg_err !== 1'b1) begin
                    errors++;
                    $display("FAIL wb_err_set: got %b expected 1", cfg_err);
                end
            end
            done_layer = 1'b1;
        end
        @(negedge clk);
        done_layer = 1'b0;
        checks++;
        if (done_CNN !== 1'b1) begin
            errors++;
            $display("FAIL wb_done: done_CNN %b expected 1", done_CNN);
        end
        @(negedge clk);
    endtask

    task automatic test_errors();
        int cyc;
        int sl0;
        do_reset();
        checks++;
        if (cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL err_cleared: got %b expected 0", cfg_err);
        end
        done_layer = 1'b1;
        @(negedge clk);
        done_layer = 1'b0;
        checks++;
        if (cfg_err !== 1'b1 || busy !== 1'b0 || count_layer !== '0) begin
            errors++;
            $display("FAIL stray_done: err %b busy %b count %0d expected 1 0 0", cfg_err, busy, count_layer);
        end
        do_reset();
        sl0 = sl_count;
        num_layer = 5'd17;
        start_CNN = 1'b1;
        @(negedge clk);
        start_CNN = 1'b0;
        checks++;
        if (cfg_err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL over_n: err %b busy %b expected 1 0", cfg_err, busy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || sl_count != sl0) begin
            errors++;
            $display("FAIL over_n_idle: busy %b launches %0d expected 0 0", busy, sl_count - sl0);
        end
        do_reset();
        cfg_write(16, mk(30));
        checks++;
        if (cfg_err !== 1'b1) begin
            errors++;
            $display("FAIL bad_addr: err %b expected 1", cfg_err);
        end
        do_reset();
        exp_q.push_back(tb_tab[0]);
        num_layer = 5'd1;
        start_CNN = 1'b1;
        wait_launch(cyc);
        @(negedge clk);
        e_check_bad_addr: begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            checks++;
            if (obs_cfg !== e) begin
                errors++;
                $display("FAIL bad_addr_entry0: got %h expected %h", obs_cfg, e);
            end
        end
        done_layer = 1'b1;
        @(negedge clk);
        done_layer = 1'b0;
        @(negedge clk);
        tb_tab[0] = mk(21);
        exp_q.push_back(tb_tab[0]);
        cfg_we    = 1'b1;
        cfg_addr  = 5'd0;
        cfg_wdata = tb_tab[0];
        num_layer = 5'd1;
        start_CNN = 1'b1;
        wait_launch(cyc);
        checks++;
        if (cyc != 2) begin
            errors++;
            $display("FAIL wr_start_latency: got %0d expected 2", cyc);
        end
        @(negedge clk);
        e_check_wr_start: begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            checks++;
            if (obs_cfg !== e) begin
                errors++;
                $display("FAIL wr_start_cfg: got %h expected %h", obs_cfg, e);
            end
        end
        done_layer = 1'b1;
        @(negedge clk);
        done_layer = 1'b0;
        checks++;
        if (done_CNN !== 1'b1 || cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL wr_start_done: done %b err %b expected 1 0", done_CNN, cfg_err);
        end
        @(negedge clk);
    endtask

    task automatic test_max_layers();
        int cyc;
        logic [DW-1:0] e;
        for (int i = 13; i < 16; i++) begin
            tb_tab[i] = mk(i);
            cfg_write(i, tb_tab[i]);
        end
        for (int i = 0; i < 16; i++) exp_q.push_back(tb_tab[i]);
        num_layer = 5'd16;
        start_CNN = 1'b1;
        for (int k = 0; k < 16; k++) begin
            wait_launch(cyc);
            checks++;
            if (cyc != 2 || count_layer !== LW'(k + 1)) begin
                errors++;
                $display("FAIL max_launch layer %0d: latency %0d count %0d expected 2 %0d", k + 1, cyc, count_layer, k + 1);
            end
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs_cfg !== e) begin
                errors++;
                $display("FAIL max_cfg layer %0d: got %h expected %h", k + 1, obs_cfg, e);
            end
            done_layer = 1'b1;
        end
        @(negedge clk);
        done_layer = 1'b0;
        checks++;
        if (done_CNN !== 1'b1 || cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL max_done: done %b err %b expected 1 0", done_CNN, cfg_err);
        end
        @(negedge clk);
    endtask

    task automatic test_rst_launch();
        int cyc;
        logic [DW-1:0] e;
        num_layer = 5'd2;
        start_CNN = 1'b1;
        wait_launch(cyc);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({start_layer, done_CNN, busy, cfg_err} !== 4'b0000 || count_layer !== '0 || obs_cfg !== '0) begin
            errors++;
            $display("FAIL rst_launch: flags %b count %0d cfg %h expected all 0",
                     {start_layer, done_CNN, busy, cfg_err}, count_layer, obs_cfg);
        end
        @(negedge clk);
        exp_q.push_back(tb_tab[0]);
        exp_q.push_back(tb_tab[1]);
        num_layer = 5'd2;
        start_CNN = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wait_launch(cyc);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs_cfg !== e || cyc != 2) begin
                errors++;
                $display("FAIL rst_rerun layer %0d: cfg %h latency %0d expected %h 2", k + 1, obs_cfg, cyc, e);
            end
            done_layer = 1'b1;
        end
        @(negedge clk);
        done_layer = 1'b0;
        checks++;
        if (done_CNN !== 1'b1) begin
            errors++;
            $display("FAIL rst_rerun_done: done_CNN %b expected 1", done_CNN);
        end
        @(negedge clk);
    endtask

    initial begin
        rst        = 1'b1;
        cfg_we     = 1'b0;
        cfg_addr   = '0;
        cfg_wdata  = '0;
        num_layer  = '0;
        start_CNN  = 1'b0;
        abort      = 1'b0;
        done_layer = 1'b0;
        test_reset();
        test_full_run();
        test_zero_layers();
        test_abort();
        test_write_busy();
        test_errors();
        test_max_layers();
        test_rst_launch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
